rv32i_instr_encoder: RTL

//  Encoder side of the RV32I decode path: takes an abstract instruction descriptor
//  (format, opcode, funct3, funct7, rd, rs1, rs2, imm) and assembles the 32-bit

---
 rtl/rv32i_pkg.sv | 49 ++++
 rtl/rv32i_imm_pack.sv | 63 ++++++
 rtl/rv32i_instr_encoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types for the RV32I instruction encoder: format codes, opcode constants,
// the input descriptor layout and the skid-buffer occupancy states.
package rv32i_pkg;

   typedef enum logic [2:0] {
      FMT_I = 3'b000,
      FMT_S = 3'b001,
      FMT_B = 3'b010,
      FMT_U = 3'b011,
      FMT_J = 3'b100,
      FMT_R = 3'b101
   } fmt_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // fmt is kept as raw bits so the illegal codes 110/111 can be carried and flagged.
   typedef struct packed {
      logic [2:0]  fmt;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } instr_desc_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_e;

   // True when v is representable as a signed value of the given bit width.
   function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
      logic [31:0] sh;
      sh = $unsigned($signed(v) >>> (bits - 1));
      return (sh == '0) || (sh == '1);
   endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational descriptor -> 32-bit RV32I word packer with illegal-descriptor flag.
// Defining IMM_RANGE_CHECK_EN also flags immediates that do not fit their format.
module rv32i_imm_pack
   import rv32i_pkg::*;
(
   input  instr_desc_t desc,
   output logic [31:0] instr,
   output logic        illegal
);

`ifdef IMM_RANGE_CHECK_EN
   localparam logic RANGE_CHECK = 1'b1;
`else
   localparam logic RANGE_CHECK = 1'b0;
`endif

   logic        is_shift;
   logic        fmt_bad;
   logic        imm_bad;
   logic [31:0] imm;

   assign imm      = desc.imm;
   assign is_shift = (desc.opcode == OP_IMM) &&
                     ((desc.funct3 == 3'b001) || (desc.funct3 == 3'b101));

   always_comb begin
      instr   = '0;
      fmt_bad = 1'b0;
      imm_bad = 1'b0;
      case (desc.fmt)
         FMT_R: instr = {desc.funct7, desc.rs2, desc.rs1, desc.funct3, desc.rd, desc.opcode};
         FMT_I: begin
            if (is_shift) begin
               instr   = {desc.funct7, imm[4:0], desc.rs1, desc.funct3, desc.rd, desc.opcode};
               imm_bad = (imm[31:5] != '0);
            end else begin
               instr   = {imm[11:0], desc.rs1, desc.funct3, desc.rd, desc.opcode};
               imm_bad = !fits_signed(imm, 12);
            end
         end
         FMT_S: begin
            instr   = {imm[11:5], desc.rs2, desc.rs1, desc.funct3, imm[4:0], desc.opcode};
            imm_bad = !fits_signed(imm, 12);
         end
         FMT_B: begin
            instr   = {imm[12], imm[10:5], desc.rs2, desc.rs1, desc.funct3,
                       imm[4:1], imm[11], desc.opcode};
            imm_bad = !fits_signed(imm, 13) || imm[0];
         end
         FMT_U: begin
            instr   = {imm[31:12], desc.rd, desc.opcode};
            imm_bad = (imm[11:0] != '0);
         end
         FMT_J: begin
            instr   = {imm[20], imm[10:1], imm[11], imm[19:12], desc.rd, desc.opcode};
            imm_bad = !fits_signed(imm, 21) || imm[0];
         end
         default: fmt_bad = 1'b1;
      endcase
      illegal = fmt_bad | (RANGE_CHECK & imm_bad);
   end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: packs descriptors into words, tags each with a byte address
// and streams them through a 2-entry skid buffer. Optional IMM_RANGE_CHECK_EN (see packer).
module rv32i_instr_encoder
   import rv32i_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   input  logic              addr_load,
   input  logic [ADDR_W-1:0] addr_base,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_err,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  instr_cnt
);

   instr_desc_t       desc;
   logic [31:0]       enc_instr;
   logic              enc_illegal;

   buf_state_e        state_reg, state_next;
   logic              in_ready_reg;
   logic [31:0]       head_instr_reg, spare_instr_reg;
   logic [ADDR_W-1:0] head_addr_reg, spare_addr_reg;
   logic              head_err_reg, spare_err_reg;
   logic [ADDR_W-1:0] addr_ctr_reg, push_addr;
   logic              err_sticky_reg;
   logic [CNT_W-1:0]  cnt_reg;

   logic              push, pop;
   logic              load_head, load_spare, head_from_spare;

   assign desc = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3, funct7: in_funct7,
                   rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

   rv32i_imm_pack u_pack (
      .desc    (desc),
      .instr   (enc_instr),
      .illegal (enc_illegal)
   );

   assign out_valid  = (state_reg != ST_EMPTY);
   assign in_ready   = in_ready_reg;
   assign out_instr  = head_instr_reg;
   assign out_addr   = head_addr_reg;
   assign out_err    = head_err_reg;
   assign err_sticky = err_sticky_reg;
   assign instr_cnt  = cnt_reg;

   assign push      = in_valid && in_ready_reg;
   assign pop       = out_valid && out_ready;
   // A coincident addr_load overrides the counter for the word being pushed.
   assign push_addr = addr_load ? addr_base : addr_ctr_reg;

   always_comb begin
      state_next      = state_reg;
      load_head       = 1'b0;
      load_spare      = 1'b0;
      head_from_spare = 1'b0;
      case (state_reg)
         ST_EMPTY: if (push) begin
            state_next = ST_ONE;
            load_head  = 1'b1;
         end
         ST_ONE: begin
            if (push && !pop) begin
               state_next = ST_TWO;
               load_spare = 1'b1;
            end else if (pop && !push) begin
               state_next = ST_EMPTY;
            end else if (push && pop) begin
               load_head  = 1'b1;
            end
         end
         ST_TWO: if (pop) begin
            state_next      = ST_ONE;
            head_from_spare = 1'b1;
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_EMPTY;
         in_ready_reg    <= 1'b1;
         head_instr_reg  <= '0;
         head_addr_reg   <= RESET_ADDR;
         head_err_reg    <= 1'b0;
         spare_instr_reg <= '0;
         spare_addr_reg  <= RESET_ADDR;
         spare_err_reg   <= 1'b0;
         addr_ctr_reg    <= RESET_ADDR;
         err_sticky_reg  <= 1'b0;
         cnt_reg         <= '0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next != ST_TWO);
         if (load_head) begin
            head_instr_reg <= enc_instr;
            head_addr_reg  <= push_addr;
            head_err_reg   <= enc_illegal;
         end else if (head_from_spare) begin
            head_instr_reg <= spare_instr_reg;
            head_addr_reg  <= spare_addr_reg;
            head_err_reg   <= spare_err_reg;
         end
         if (load_spare) begin
            spare_instr_reg <= enc_instr;
            spare_addr_reg  <= push_addr;
            spare_err_reg   <= enc_illegal;
         end
         addr_ctr_reg <= push ? push_addr + ADDR_W'(4) : push_addr;
         if (push && enc_illegal)
            err_sticky_reg <= 1'b1;
         if (pop)
            cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule
